pmu_frame_serializer: RTL and testbench
=======================================

// Module: pmu_frame_serializer
// PURPOSE
// Upstream feeder for the PMU: packs 64-bit configuration words into the serial PMU frame and drives it onto the PMU data/enable lines on tck_i.
// Frame order: 64-bit header, optional CRC byte, then per block 64 data bits and an optional CRC byte. Used by the on-chip loader and the test harness in place of raw JTAG shifting.
// PARAMETERS
// WORD_W      64   block width in bits; fixed to the PMU block size
// CRC_W       8    CRC width; fixed to the PMU checker
// PORTS
// tck_i          in   1   clock; same clock as the PMU
// rst_i          in   1   reset
// start_i        in   1   1-cycle pulse; begin a frame (sampled only in IDLE)
// num_blocks_i   in   32  block count; becomes header[31:0]
// last_len_i     in   32  valid bits in last block; becomes header[63:32]
// crc_mode_i     in   1   1 = insert CRC bytes (PMU checksum_en_i must match)
// word_i         in   64  block payload, bit 0 transmitted first
// word_valid_i   in   1   payload valid
// word_ready_o   out  1   holding register empty; a transfer occurs when valid&&ready
// data_o         out  1   serial bit to PMU data_i
// en_o           out  1   to PMU en_i; high for the whole frame
// busy_o         out  1   frame in progress
// done_o         out  1   1-cycle pulse after the final bit
// err_o          out  1   1-cycle pulse on reject or underrun
// BEHAVIOUR
// - Reset is synchronous and active-high (rst_i), with a single clock (tck_i).
// - Reset state: IDLE. data_o=0, en_o=0, busy_o=0, done_o=0, err_o=0, word_ready_o=1, holding register empty.
// - Reset mid-frame: all outputs return to reset values on the next edge. The PMU sees en low and aborts.
// - Outputs are registered. A start_i sampled in cycle N gives en_o=1 with header bit 0 on data_o in cycle N+1.
// - States and transitions:
//   IDLE: on start_i, latch hdr={last_len_i,num_blocks_i} and go to HDR.
//         If num_blocks_i==0 or last_len_i==0 or last_len_i>64, pulse err_o and stay in IDLE.
//   HDR:  64 cycles, shift hdr LSB first. Then go to HCRC if crc_mode_i, else DATA.
//   HCRC: 8 cycles, send CRC remainder bit 7 first. Then go to DATA.
//   DATA: 64 cycles, shift the holding register LSB first. Decrement blk_left at the last bit.
//         Then go to DCRC if crc_mode_i. Otherwise go to DATA if blk_left!=0, else to DONE.
//   DCRC: 8 cycles. Then go to DATA if blk_left!=0, else to DONE.
//   DONE: 1 cycle with en_o=0 and done_o=1, then IDLE.
// - crc_mode_i is sampled at start_i and held for the whole frame.
// - The data bit count is always 64. Bits of the last block beyond last_len_i are sent as given; the PMU gates progclk.
// - Holding register: 1 entry. word_ready_o=1 while empty, including during IDLE/HDR, so the first block is prefetched.
//   It frees on the cycle its last bit is shifted into the shifter; a new word is accepted the same cycle.
// - Underrun: on entry to DATA with the holding register empty, drop en_o to 0, pulse err_o and go to IDLE.
//   The frame must not stall with en_o high.
// - CRC: LFSR poly 0xEB (x^8+x^7+x^6+x^5+x^3+x+1).
//   Update per bit: c0=d^c7, c1=c0^c7, c2=c1, c3=c2^c7, c4=c3, c5=c4^c7, c6=c5^c7, c7=c6^c7.
//   Cleared to 0 at the start of each segment (header or block). Input is the transmitted bits of that segment only.
//   The remainder is frozen on entry to HCRC/DCRC. The PMU LFSR is then 0 after the CRC byte.
// - start_i is ignored while busy_o=1.
// - busy_o=1 in HDR, HCRC, DATA and DCRC.
// - Counters: 6-bit bit counter that wraps 63->0 at segment end; 3-bit CRC counter; 32-bit blk_left.
//   No other arithmetic exceeds these widths.
// TESTING
// 1. crc_mode=1, num_blocks=1, last_len=64, word preloaded -> en_o high 144 cycles (64+8+64+8), done_o once, PMU flag_o never 1.
// 2. crc_mode=0, num_blocks=3, last_len=20, 3 words -> en_o high 256 cycles, no CRC bytes, data_o matches the concatenated bits.
// 3. Header 0x00000040_00000001 -> first 8 data_o bits 1,0,0,0,0,0,0,0; HCRC byte equals the LFSR model; PMU capture flag_o=0.
// 4. num_blocks=2, word_valid withheld after the first block -> err_o pulse at the second DATA entry, en_o=0, state IDLE, done_o=0.
// 5. start_i with num_blocks_i=0 -> err_o pulse next cycle, en_o stays 0. A start_i pulse mid-frame has no effect on the bit count.
// 6. rst_i asserted during DATA bit 30 -> next cycle en_o=0, busy_o=0, word_ready_o=1. A fresh start runs case 1 correctly.

Source files
------------

// File: rtl/pmu_frame_serializer.sv
// PMU frame serializer: packs a 64-bit header and 64-bit payload blocks,
// optionally each followed by a CRC byte, into the serial PMU data/enable stream.
module pmu_frame_serializer #(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned CRC_W  = 8
) (
    input  logic              tck_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       num_blocks_i,
    input  logic [31:0]       last_len_i,
    input  logic              crc_mode_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    output logic              data_o,
    output logic              en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_HCRC = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DCRC = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]        r_state;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_hold;
    logic              r_hold_full;
    logic [5:0]        r_bit_cnt;
    logic [2:0]        r_crc_cnt;
    logic [31:0]       r_blk_left;
    logic [CRC_W-1:0]  r_crc;
    logic              r_crc_mode;
    logic              r_data;
    logic              r_en;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [2:0]        w_next_state;
    logic              w_next_busy;
    logic              w_start_ok;
    logic              w_reject;
    logic              w_enter_data;
    logic              w_underrun;
    logic              w_avail;
    logic [WORD_W-1:0] w_word;
    logic [63:0]       w_hdr;
    logic [31:0]       w_blk_dec;
    logic              w_bad_req;
    logic [CRC_W-1:0]  w_crc_next;

    // One LFSR step over the bit currently on the wire.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
        crc_step = {c[6] ^ c[7], c[5] ^ c[7], c[4] ^ c[7], c[3],
                    c[2] ^ c[7], c[1], c[0] ^ c[7], d ^ c[7]};
    endfunction

    assign w_hdr       = {last_len_i, num_blocks_i};
    assign w_bad_req   = (num_blocks_i == 32'd0) || (last_len_i == 32'd0) ||
                         (last_len_i > 32'd64);
    // A word offered on the same edge the shifter reloads bypasses the holding register.
    assign w_avail     = r_hold_full | word_valid_i;
    assign w_word      = r_hold_full ? r_hold : word_i;
    assign w_blk_dec   = r_blk_left - 32'd1;
    assign w_crc_next  = crc_step(r_crc, r_data);
    assign w_next_busy = (w_next_state == S_HDR) || (w_next_state == S_HCRC) ||
                         (w_next_state == S_DATA) || (w_next_state == S_DCRC);

    // Next-state decode, including the underrun check on every DATA entry.
    always_comb begin
        w_next_state = r_state;
        w_start_ok   = 1'b0;
        w_reject     = 1'b0;
        w_enter_data = 1'b0;
        w_underrun   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (w_bad_req) begin
                        w_reject = 1'b1;
                    end else begin
                        w_start_ok   = 1'b1;
                        w_next_state = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (r_bit_cnt == 6'd63) begin
                    if (r_crc_mode) w_next_state = S_HCRC;
                    else            w_enter_data = 1'b1;
                end
            end
            S_HCRC: begin
                if (r_crc_cnt == 3'd7) w_enter_data = 1'b1;
            end
            S_DATA: begin
                if (r_bit_cnt == 6'd63) begin
                    if (r_crc_mode)              w_next_state = S_DCRC;
                    else if (w_blk_dec != 32'd0) w_enter_data = 1'b1;
                    else                         w_next_state = S_DONE;
                end
            end
            S_DCRC: begin
                if (r_crc_cnt == 3'd7) begin
                    if (r_blk_left != 32'd0) w_enter_data = 1'b1;
                    else                     w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (w_enter_data) begin
            if (w_avail) begin
                w_next_state = S_DATA;
            end else begin
                w_underrun   = 1'b1;
                w_next_state = S_IDLE;
            end
        end
    end

    // State, shifter, CRC, holding register and registered outputs.
    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= 6'd0;
            r_crc_cnt   <= 3'd0;
            r_blk_left  <= 32'd0;
            r_crc       <= '0;
            r_crc_mode  <= 1'b0;
            r_data      <= 1'b0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_en    <= w_next_busy;
            r_busy  <= w_next_busy;
            r_done  <= (w_next_state == S_DONE);
            r_err   <= w_reject | w_underrun;

            if (w_enter_data && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (word_valid_i && !r_hold_full && !w_enter_data) begin
                r_hold      <= word_i;
                r_hold_full <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_data     <= w_hdr[0];
                        r_shift    <= {1'b0, w_hdr[63:1]};
                        r_crc      <= '0;
                        r_bit_cnt  <= 6'd0;
                        r_crc_mode <= crc_mode_i;
                        r_blk_left <= num_blocks_i;
                    end
                end
                S_HDR, S_DATA: begin
                    r_crc     <= w_crc_next;
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    r_data    <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    if (r_bit_cnt == 6'd63) begin
                        if (r_state == S_DATA) r_blk_left <= w_blk_dec;
                        // Remainder is frozen here and sent MSB first.
                        r_data    <= w_crc_next[7];
                        r_crc_cnt <= 3'd0;
                    end
                end
                S_HCRC, S_DCRC: begin
                    r_crc     <= r_crc << 1;
                    r_data    <= r_crc[6];
                    r_crc_cnt <= r_crc_cnt + 3'd1;
                end
                default: ;
            endcase

            if (w_enter_data && w_avail) begin
                r_data    <= w_word[0];
                r_shift   <= {1'b0, w_word[WORD_W-1:1]};
                r_crc     <= '0;
                r_bit_cnt <= 6'd0;
            end
            if (!w_next_busy) r_data <= 1'b0;
        end
    end

    assign word_ready_o = ~r_hold_full;
    assign data_o       = r_data;
    assign en_o         = r_en;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule

// File: tb/tb_pmu_frame_serializer.sv
// Directed bench for pmu_frame_serializer: captures the serial frame and
// compares it against streams and CRC bytes built from the input words.
module tb_pmu_frame_serializer;

    logic        tck;
    logic        rst;
    logic        start;
    logic [31:0] nb;
    logic [31:0] ll;
    logic        crc_mode;
    logic [63:0] word;
    logic        word_valid;
    logic        word_ready;
    logic        data;
    logic        en;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [63:0] words [0:3];
    logic        cap  [0:511];
    logic        expb [0:511];
    int          ncap, ne, en_cnt, done_cnt, err_cnt, err_cycle, first_en, feed_idx;
    logic        snap_en, snap_busy, snap_ready, snap_data;

    pmu_frame_serializer dut (
        .tck_i        (tck),
        .rst_i        (rst),
        .start_i      (start),
        .num_blocks_i (nb),
        .last_len_i   (ll),
        .crc_mode_i   (crc_mode),
        .word_i       (word),
        .word_valid_i (word_valid),
        .word_ready_o (word_ready),
        .data_o       (data),
        .en_o         (en),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC of one 64-bit segment, bit 0 first.
    function automatic logic [7:0] crc64(input logic [63:0] v);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            fb = c[7];
            c  = {c[6] ^ fb, c[5] ^ fb, c[4] ^ fb, c[3], c[2] ^ fb, c[1], c[0] ^ fb, v[i] ^ fb};
        end
        return c;
    endfunction

    task automatic push64(input logic [63:0] v, input logic add_crc);
        logic [7:0] c;
        for (int i = 0; i < 64; i++) begin
            expb[ne] = v[i];
            ne++;
        end
        if (add_crc) begin
            c = crc64(v);
            for (int j = 7; j >= 0; j--) begin
                expb[ne] = c[j];
                ne++;
            end
        end
    endtask

    task automatic chk_stream(input string tag);
        int nbad;
        nbad = 0;
        for (int i = 0; i < ne; i++) if (cap[i] !== expb[i]) nbad++;
        chk({tag, "_len"}, ncap, ne);
        chk({tag, "_bits_wrong"}, nbad, 0);
    endtask

    // Starts a frame and runs ncyc cycles, feeding up to nfeed words on demand.
    task automatic run_frame(input logic [31:0] nblk, input logic [31:0] llen, input logic cm,
                             input int nfeed, input int ncyc, input int mid_start,
                             input int rst_at);
        logic acc;
        ncap = 0; en_cnt = 0; done_cnt = 0; err_cnt = 0; err_cycle = -1;
        first_en = -1; feed_idx = 0;
        @(negedge tck);
        nb = nblk; ll = llen; crc_mode = cm; start = 1'b1;
        word_valid = (nfeed > 0);
        word = words[0];
        acc = word_valid && word_ready;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge tck);
            #1;
            start = (c == mid_start);
            rst   = (c == rst_at);
            if (acc) feed_idx++;
            word_valid = (feed_idx < nfeed);
            word = words[feed_idx & 3];
            @(negedge tck);
            if (en) begin
                if (ncap < 512) cap[ncap] = data;
                ncap++;
                en_cnt++;
                if (first_en < 0) first_en = c;
            end
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                if (err_cycle < 0) err_cycle = c;
            end
            if (c == rst_at + 1) begin
                snap_en = en; snap_busy = busy; snap_ready = word_ready; snap_data = data;
            end
            acc = word_valid && word_ready;
        end
        word_valid = 1'b0;
        start = 1'b0;
        rst = 1'b0;
    endtask

    logic [63:0] hdr;
    logic [7:0]  first8;
    logic [7:0]  hcrc;
    logic [31:0] bad_ll [0:2];
    logic [31:0] bad_nb [0:2];

    initial begin
        words[0] = 64'hA5C3_0F96_1E2D_3C4B;
        words[1] = 64'h0123_4567_89AB_CDEF;
        words[2] = 64'hFFFF_0000_8000_0001;
        words[3] = 64'h0;
        rst = 1'b1; start = 1'b0; nb = 32'd0; ll = 32'd0; crc_mode = 1'b0;
        word = 64'h0; word_valid = 1'b0;
        repeat (3) @(posedge tck);
        #1 rst = 1'b0;
        @(negedge tck);
        chk("rst_data", data, 0);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", word_ready, 1);

        // CRC frame, one block, header 0x00000040_00000001.
        hdr = {32'd64, 32'd1};
        run_frame(32'd1, 32'd64, 1'b1, 1, 150, -1, -1);
        ne = 0;
        push64(hdr, 1'b1);
        push64(words[0], 1'b1);
        chk("t1_first_en_cycle", first_en, 1);
        chk("t1_en_cycles", en_cnt, 144);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_err_pulses", err_cnt, 0);
        chk_stream("t1_stream");
        for (int i = 0; i < 8; i++) first8[i] = cap[i];
        chk("t3_first8", first8, 8'h01);
        for (int j = 0; j < 8; j++) hcrc[7-j] = cap[64+j];
        chk("t3_hcrc", hcrc, crc64(hdr));
        chk("t1_idle_busy", busy, 0);

        // No CRC, three blocks, stray start mid-frame.
        run_frame(32'd3, 32'd20, 1'b0, 3, 262, 100, -1);
        ne = 0;
        push64({32'd20, 32'd3}, 1'b0);
        push64(words[0], 1'b0);
        push64(words[1], 1'b0);
        push64(words[2], 1'b0);
        chk("t2_en_cycles", en_cnt, 256);
        chk("t2_done_pulses", done_cnt, 1);
        chk("t2_err_pulses", err_cnt, 0);
        chk_stream("t2_stream");

        // Underrun at the second block.
        run_frame(32'd2, 32'd64, 1'b0, 1, 140, -1, -1);
        chk("t4_en_cycles", en_cnt, 128);
        chk("t4_err_pulses", err_cnt, 1);
        chk("t4_err_cycle", err_cycle, 129);
        chk("t4_done_pulses", done_cnt, 0);
        chk("t4_busy_after", busy, 0);
        chk("t4_en_after", en, 0);

        // Rejected requests.
        bad_nb[0] = 32'd0; bad_ll[0] = 32'd64;
        bad_nb[1] = 32'd2; bad_ll[1] = 32'd0;
        bad_nb[2] = 32'd2; bad_ll[2] = 32'd65;
        for (int k = 0; k < 3; k++) begin
            @(negedge tck);
            nb = bad_nb[k]; ll = bad_ll[k]; start = 1'b1;
            @(posedge tck);
            #1 start = 1'b0;
            @(negedge tck);
            chk($sformatf("t5_rej%0d_err", k), err, 1);
            chk($sformatf("t5_rej%0d_en", k), en, 0);
            @(negedge tck);
            chk($sformatf("t5_rej%0d_err_cleared", k), err, 0);
            chk($sformatf("t5_rej%0d_busy", k), busy, 0);
        end

        // Reset during DATA bit 30, then a clean frame.
        run_frame(32'd1, 32'd64, 1'b1, 1, 110, -1, 103);
        chk("t6_en_after_rst", snap_en, 0);
        chk("t6_busy_after_rst", snap_busy, 0);
        chk("t6_ready_after_rst", snap_ready, 1);
        chk("t6_data_after_rst", snap_data, 0);
        chk("t6_en_before_rst", en_cnt, 103);
        run_frame(32'd1, 32'd64, 1'b1, 1, 150, -1, -1);
        ne = 0;
        push64(hdr, 1'b1);
        push64(words[0], 1'b1);
        chk("t6_rerun_en_cycles", en_cnt, 144);
        chk("t6_rerun_done", done_cnt, 1);
        chk_stream("t6_rerun_stream");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
